llc_bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer for the shared snoop bus feeding the last-level cache. It grants one private-cache requester at a time and broadcasts its coherence command (BusRd, BusRdx, BusUpgr, Flush). It collects snoop responses from the other caches, sequences any dirty-line flush or memory access, and returns the MESI state the requester must install.

---
 rtl/llc_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_llc_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/llc_bus_arbiter.sv
// Round-robin snoop-bus arbiter: grants one cache, broadcasts its command, collects snoops, sequences flush/memory, returns fill state.
// Grant 1 cycle after request; new requests wait in IDLE while a transaction runs; memory waits on mem_ack.
module llc_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int SNOOP_TMO = 8,
  localparam int SRC_W    = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [2*NUM_CORES-1:0]        req_cmd,
  input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
  output logic [NUM_CORES-1:0]          gnt,
  output logic                          bus_valid,
  output logic [1:0]                    bus_cmd,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [SRC_W-1:0]              bus_src,
  input  logic [NUM_CORES-1:0]          snp_valid,
  input  logic [NUM_CORES-1:0]          snp_hit,
  input  logic [NUM_CORES-1:0]          snp_hitm,
  output logic                          mem_req,
  output logic                          mem_we,
  input  logic                          mem_ack,
  output logic                          done,
  output logic [1:0]                    fill_state
);

  localparam logic [1:0] CMD_RD    = 2'b00;
  localparam logic [1:0] CMD_UPGR  = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;
  localparam logic [1:0] MESI_M    = 2'b00;
  localparam logic [1:0] MESI_E    = 2'b01;
  localparam logic [1:0] MESI_S    = 2'b10;
  localparam logic [1:0] MESI_I    = 2'b11;

  typedef enum logic [2:0] {IDLE, BUS, SNOOP, FLUSH, MEM, DONE} state_t;

  typedef struct packed {
    logic [NUM_CORES-1:0] rcv;
    logic                 hit;
    logic                 hitm;
    logic [7:0]           cnt;
  } snp_acc_t;

  state_t               state;
  snp_acc_t             acc;
  logic [SRC_W-1:0]     last_grant;
  logic [SRC_W-1:0]     win;
  logic [1:0]           win_cmd;
  logic [ADDR_W-1:0]    win_addr;
  logic [NUM_CORES-1:0] src_mask;
  logic [NUM_CORES-1:0] eff_valid;
  logic [NUM_CORES-1:0] rcv_nxt;
  logic                 hit_nxt;
  logic                 hitm_nxt;
  logic                 snoop_end;
  logic [1:0]           fill_calc;

  // Scan offsets from farthest to nearest so the core closest after last_grant wins.
  always_comb begin
    win      = '0;
    win_cmd  = '0;
    win_addr = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (req_valid[i] && (((int'(last_grant) + k) % NUM_CORES) == i)) begin
          win      = SRC_W'(i);
          win_cmd  = req_cmd[2*i +: 2];
          win_addr = req_addr[ADDR_W*i +: ADDR_W];
        end
      end
    end
  end

  assign src_mask  = {{(NUM_CORES-1){1'b0}}, 1'b1} << bus_src;
  assign eff_valid = snp_valid & ~src_mask;
  assign rcv_nxt   = acc.rcv | eff_valid;
  assign hit_nxt   = acc.hit  | (|(snp_hit  & eff_valid));
  assign hitm_nxt  = acc.hitm | (|(snp_hitm & eff_valid));
  // cnt holds completed SNOOP cycles, so the current cycle is cnt+1.
  assign snoop_end = (&(rcv_nxt | src_mask)) || (acc.cnt == 8'(SNOOP_TMO - 1));

  always_comb begin
    fill_calc = MESI_M;
    case (bus_cmd)
      CMD_RD:    fill_calc = (acc.hit || acc.hitm) ? MESI_S : MESI_E;
      CMD_FLUSH: fill_calc = MESI_I;
      default:   fill_calc = MESI_M;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(NUM_CORES - 1);
      acc        <= '0;
      gnt        <= '0;
      bus_valid  <= 1'b0;
      bus_cmd    <= '0;
      bus_addr   <= '0;
      bus_src    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      fill_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt        <= {{(NUM_CORES-1){1'b0}}, 1'b1} << win;
            bus_valid  <= 1'b1;
            bus_cmd    <= win_cmd;
            bus_addr   <= win_addr;
            bus_src    <= win;
            last_grant <= win;
            state      <= BUS;
          end
        end
        BUS: begin
          gnt       <= '0;
          bus_valid <= 1'b0;
          if (bus_cmd == CMD_FLUSH) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            state   <= MEM;
          end else begin
            state   <= SNOOP;
          end
        end
        SNOOP: begin
          acc.rcv  <= rcv_nxt;
          acc.hit  <= hit_nxt;
          acc.hitm <= hitm_nxt;
          acc.cnt  <= acc.cnt + 8'd1;
          if (snoop_end) begin
            if (bus_cmd == CMD_UPGR) begin
              done       <= 1'b1;
              fill_state <= fill_calc;
              state      <= DONE;
            end else if (hitm_nxt) begin
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              state   <= FLUSH;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= MEM;
            end
          end
        end
        FLUSH, MEM: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            done       <= 1'b1;
            fill_state <= fill_calc;
            state      <= DONE;
          end
        end
        DONE: begin
          done       <= 1'b0;
          fill_state <= '0;
          acc        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_bus_arbiter.sv
// Directed and randomized transactions on the snoop-bus arbiter, checked against a transaction-level model.
module tb_llc_bus_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int TMO = 8;
  localparam int SW  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic            bus_valid;
  logic [1:0]      bus_cmd;
  logic [AW-1:0]   bus_addr;
  logic [SW-1:0]   bus_src;
  logic [N-1:0]    snp_valid, snp_hit, snp_hitm;
  logic            mem_req, mem_we, mem_ack, done;
  logic [1:0]      fill_state;

  llc_bus_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .SNOOP_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .gnt(gnt), .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_src(bus_src),
    .snp_valid(snp_valid), .snp_hit(snp_hit), .snp_hitm(snp_hitm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .done(done), .fill_state(fill_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_model;
  int rsp_cyc [N];          // SNOOP cycle (1-based) in which core responds; 0 = never
  logic [N-1:0] rsp_hit, rsp_hitm;
  logic [1:0]   t_cmd  [N];
  logic [AW-1:0] t_addr [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (((m >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    return -1;
  endfunction

  // path: 0 = none, 1 = memory read, 2 = dirty flush write-back, 3 = Flush command write
  task automatic model(input int src, input logic [1:0] cmd,
                       output int len, output int path, output logic [1:0] fill);
    bit all_rsp = 1;
    int mx = 0;
    bit hit = 0, hitm = 0;
    len = 0; path = 3; fill = 2'b11;
    if (cmd != 2'b11) begin
      for (int i = 0; i < N; i++) begin
        if (i == src) continue;
        if (rsp_cyc[i] < 1 || rsp_cyc[i] > TMO) all_rsp = 0;
        else if (rsp_cyc[i] > mx) mx = rsp_cyc[i];
      end
      len = all_rsp ? mx : TMO;
      for (int i = 0; i < N; i++)
        if (i != src && rsp_cyc[i] >= 1 && rsp_cyc[i] <= len) begin
          hit  = hit  | rsp_hit[i];
          hitm = hitm | rsp_hitm[i];
        end
      if (cmd == 2'b10) begin path = 0; fill = 2'b00; end
      else begin
        path = hitm ? 2 : 1;
        fill = (cmd == 2'b01) ? 2'b00 : ((hit || hitm) ? 2'b10 : 2'b01);
      end
    end
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after DONE.
  task automatic run_txn(input logic [N-1:0] mask, input bit hold, input int ack_dly);
    int w, len, path;
    logic [1:0] fill;
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_cmd[2*i +: 2]   = t_cmd[i];
      req_addr[AW*i +: AW] = t_addr[i];
    end
    w = rr_pick(mask, last_model);
    last_model = w;
    model(w, t_cmd[w], len, path, fill);
    tick;
    chk("gnt", gnt, 64'(1) << w);
    chk("bus_valid", bus_valid, 1);
    chk("bus_cmd", bus_cmd, t_cmd[w]);
    chk("bus_addr", bus_addr, t_addr[w]);
    chk("bus_src", bus_src, w);
    if (!hold) req_valid = '0;
    snp_valid = '1; snp_hit = '1; snp_hitm = '1; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    snp_valid = '0; snp_hit = '0; snp_hitm = '0;
    if (path != 3) begin
      for (int k = 1; k <= len; k++) begin
        chk("snoop_quiet", {gnt, bus_valid, mem_req, done}, 0);
        chk("addr_held", bus_addr, t_addr[w]);
        for (int i = 0; i < N; i++) snp_valid[i] = (rsp_cyc[i] == k);
        snp_hit = rsp_hit; snp_hitm = rsp_hitm;
        tick;
      end
      snp_valid = '0; snp_hit = '0; snp_hitm = '0;
    end
    if (path != 0) begin
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, (path != 1));
      chk("no_early_done", done, 0);
      for (int d = 0; d < ack_dly; d++) begin
        tick;
        chk("mem_req_hold", {mem_req, done}, 2'b10);
      end
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
    end
    chk("done", done, 1);
    chk("fill_state", fill_state, fill);
    chk("mem_req_off", mem_req, 0);
    chk("src_held", bus_src, w);
    snp_valid = '1; snp_hit = '1; snp_hitm = '1;
    tick;
    snp_valid = '0; snp_hit = '0; snp_hitm = '0;
    chk("done_pulse", done, 0);
  endtask

  task automatic set_rsp(input int c0, input int c1, input int c2, input int c3,
                         input logic [N-1:0] h, input logic [N-1:0] hm);
    rsp_cyc[0] = c0; rsp_cyc[1] = c1; rsp_cyc[2] = c2; rsp_cyc[3] = c3;
    rsp_hit = h; rsp_hitm = hm;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '1; req_cmd = '0; req_addr = '0;
    snp_valid = '0; snp_hit = '0; snp_hitm = '0; mem_ack = 1'b0;
    for (int i = 0; i < N; i++) begin t_cmd[i] = 2'b10; t_addr[i] = 32'h100 * (i + 1); end
    tick; tick;
    chk("reset_outputs", {gnt, bus_valid, bus_cmd, bus_addr, bus_src, mem_req, mem_we, done, fill_state}, 0);
    rst = 1'b1;
    last_model = N - 1;

    // All cores hold BusUpgr requests: grants rotate 0,1,2,3,0.
    set_rsp(1, 1, 1, 1, '0, '0);
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 1, 0);
    req_valid = '0;

    t_cmd[2] = 2'b00; t_addr[2] = 32'h1000;
    set_rsp(1, 1, 0, 1, '0, '0);
    run_txn(4'b0100, 0, 3);

    t_cmd[1] = 2'b00; t_addr[1] = 32'h3000;
    set_rsp(1, 0, 1, 1, '0, 4'b1000);
    run_txn(4'b0010, 0, 1);

    t_cmd[0] = 2'b01; t_addr[0] = 32'h4000;
    set_rsp(1, 1, 1, 1, 4'b0100, 4'b0001);
    run_txn(4'b0001, 0, 0);

    t_cmd[3] = 2'b00; t_addr[3] = 32'h5000;
    set_rsp(2, 0, 2, 0, '0, '0);
    run_txn(4'b1000, 0, 2);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        t_cmd[i]  = 2'($urandom_range(0, 3));
        t_addr[i] = $urandom;
        rsp_cyc[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TMO + 2))
                                                  : int'($urandom_range(1, 4));
      end
      rsp_hit  = 4'($urandom);
      rsp_hitm = 4'($urandom);
      run_txn(4'($urandom_range(1, 15)), 0, int'($urandom_range(0, 4)));
    end

    // Flush interrupted by reset while waiting for memory.
    t_cmd[1] = 2'b11; t_addr[1] = 32'h2040;
    req_valid = 4'b0010;
    req_cmd[3:2] = t_cmd[1];
    req_addr[AW +: AW] = t_addr[1];
    last_model = rr_pick(4'b0010, last_model);
    tick;
    chk("flush_gnt", gnt, 4'b0010);
    req_valid = '0;
    tick;
    chk("flush_mem", {mem_req, mem_we}, 2'b11);
    tick; tick;
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {gnt, bus_valid, bus_cmd, bus_addr, bus_src, mem_req, mem_we, done, fill_state}, 0);
    mem_ack = 1'b1;
    tick;
    chk("in_reset", {mem_req, done}, 0);
    rst = 1'b1;
    mem_ack = 1'b0;
    tick;
    chk("no_done_after_reset", {done, mem_req, bus_valid}, 0);
    last_model = N - 1;
    t_cmd[0] = 2'b10; t_cmd[2] = 2'b10;
    set_rsp(1, 1, 1, 1, '0, '0);
    run_txn(4'b0101, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
